arb_bin_ram: RTL and testbench
==============================

Name: arb_bin_ram

Overview:
- Round-robin arbiter and sequencer for the single-port bin RAM that holds clause/variable bins.
- Shares the RAM between up to NUM_REQ requesters: rdinfo, load_bin, update_bin and find_global_bkt_lvl, in index order 0..3.
- Grants one requester at a time. A requester can lock the grant so a whole bin transfer completes without interruption.
- Returns read data, tagged, to the requester that issued the read. This holds even after the grant has moved to another requester.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH_ADDR, 16, bin RAM address width.
- WIDTH_DATA, 32, bin RAM data width.
- RD_LAT, 1, RAM read latency in cycles from ram_en_o to valid ram_rdata_i; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- req_i  in  NUM_REQ  per-requester access request; an access is issued each granted cycle
- lock_i  in  NUM_REQ  hold the grant even while req_i is low
- we_i  in  NUM_REQ  1 = write, 0 = read
- addr_i  in  NUM_REQ*WIDTH_ADDR  flattened addresses; requester k at [k*WIDTH_ADDR +: WIDTH_ADDR]
- wdata_i  in  NUM_REQ*WIDTH_DATA  flattened write data, same packing
- gnt_o  out  NUM_REQ  registered one-hot grant
- rvalid_o  out  NUM_REQ  one-cycle read-data-valid, routed to the issuing requester
- rdata_o  out  WIDTH_DATA  shared read data, equals ram_rdata_i
- busy_o  out  1  an owner exists or a read is in flight
- ram_en_o  out  1  RAM enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  WIDTH_ADDR  RAM address
- ram_wdata_o  out  WIDTH_DATA  RAM write data
- ram_rdata_i  in  WIDTH_DATA  RAM read data

Behaviour:
- Reset: while rst==0 at a clk edge:
  - state goes to ARB; gnt_o, rvalid_o and busy_o go to 0.
  - The round-robin pointer goes to 0.
  - The read-tag pipeline is flushed; in-flight reads never produce rvalid_o.
- Reset mid-operation:
  - The same rule applies mid-transfer; the transfer is lost and the requester must re-request.
  - The RAM outputs are forced to 0 in the reset cycle.
- State ARB (no owner):
  - If any req_i is high, search starting at the pointer and wrapping from NUM_REQ-1 to 0. The first high bit k wins.
  - Next cycle: gnt_o = one-hot(k), state OWN, owner = k, pointer = (k+1) mod NUM_REQ.
  - lock_i alone, without req_i, does not win arbitration.
  - Latency from req rise to gnt_o is 1 cycle.
- State OWN:
  - RAM signals are combinational from the owner: ram_en_o = req_i[owner]; ram_we_o = req_i[owner] & we_i[owner]; ram_addr_o and ram_wdata_o are the owner's slices.
  - When the owner is not requesting, ram_en_o = 0 and addr/wdata are 0.
  - Release condition: req_i[owner]==0 and lock_i[owner]==0, sampled at the edge.
  - On release, arbitration is performed in the same cycle over the current req_i. Handover happens with zero bubble: the next cycle has the new gnt_o, or ARB with gnt_o = 0 if no requests are pending.
  - The released owner cannot win that cycle, because its req_i is low.
- Non-granted requesters:
  - Their req/we/addr/wdata are ignored; they simply wait.
  - No request is ever dropped or reordered.
- Read return:
  - Each cycle with ram_en_o & ~ram_we_o pushes the owner index, with a valid bit, into an RD_LAT-deep shift pipeline.
  - At the pipeline output, rvalid_o[tag] = 1 for exactly one cycle; rdata_o = ram_rdata_i at all times.
  - Read return is independent of the current grant. A read issued in the owner's last cycle still returns to that owner after handover.
- Writes complete in the issue cycle and produce no rvalid_o.
- busy_o = (state==OWN) | any valid bit in the tag pipeline.
- Simultaneous events:
  - Owner drops req while holding lock: the grant is kept and the RAM is idle.
  - Owner drops lock and req in the same cycle as another requester raises req: handover occurs next cycle.
  - All requesters high continuously: grants rotate strictly by pointer, so each waits at most NUM_REQ-1 ownerships.
- There is no timeout on lock. The owner is responsible for releasing it.

Test Plan:
- Single read, RD_LAT=1: req_i=4'b0010, addr=0x0040, we=0, held 1 cycle after grant.
  - gnt_o=4'b0010 one cycle after req.
  - ram_en_o=1 with ram_addr_o=0x0040.
  - rvalid_o=4'b0010 the following cycle, with rdata_o = RAM contents.
- Simultaneous requests, pointer at 0: req_i=4'b1001, each holding 2 accesses.
  - Grant order: 0, then 3 with zero bubble, then ARB with gnt_o = 0.
  - Pointer ends at 0 after the wrap.
- Lock hold: requester 2 sets lock_i=1 and drops req for 3 cycles while req_i[0]=1.
  - gnt_o stays 4'b0100 with ram_en_o=0.
  - Requester 0 is granted exactly 1 cycle after lock_i[2] falls.
- In-flight read across handover, RD_LAT=3: owner 1 issues its last read, then releases; requester 3 is granted next.
  - rvalid_o[1] pulses 3 cycles after the issue while gnt_o=4'b1000.
  - rvalid_o[3] is not asserted for that read.
- Reset mid-burst: rst=0 for one cycle while owner 2 has 2 reads in flight.
  - gnt_o, rvalid_o and busy_o are 0 the next cycle.
  - No rvalid_o pulses afterwards.
  - With req_i=4'b0001 after reset, requester 0 is granted first.
- Fairness: all req_i held high for 12 ownerships, each of 1 access.
  - Grant sequence is 0, 1, 2, 3, 0, 1, ...
  - Writes to distinct addresses are read back correct.

Source files
------------

// File: rtl/arb_bin_ram.sv
// arb_bin_ram
//   Round-robin arbiter and sequencer for the single-port bin RAM.
//   Requesters (index order): 0 rdinfo, 1 load_bin, 2 update_bin,
//   3 find_global_bkt_lvl. One requester owns the RAM at a time, and
//   lock_i lets the owner keep the grant between accesses. Every read
//   is tagged with the issuing owner. The tag travels through an RD_LAT
//   deep pipeline, so read data returns to the issuer even after the
//   grant has moved to another requester.
//
// Ports
//   clk, rst        clock, synchronous active-low reset
//   req_i           per-requester access request (one access per granted cycle)
//   lock_i          owner keeps the grant while req_i is low
//   we_i            1 = write, 0 = read
//   addr_i/wdata_i  flattened per-requester address / write data
//   gnt_o           registered one-hot grant
//   rvalid_o        one-cycle read-valid, routed to the issuing requester
//   rdata_o         shared read data (pass-through of ram_rdata_i)
//   busy_o          owner present or read in flight
//   ram_*           single-port RAM interface
//
// state | meaning
// ARB   | no owner; arbitrate over req_i
// OWN   | owner_q drives the RAM until it drops both req and lock
module arb_bin_ram #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH_ADDR = 16,
  parameter int WIDTH_DATA = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_i,
  input  logic [NUM_REQ-1:0]               lock_i,
  input  logic [NUM_REQ-1:0]               we_i,
  input  logic [NUM_REQ*WIDTH_ADDR-1:0]    addr_i,
  input  logic [NUM_REQ*WIDTH_DATA-1:0]    wdata_i,
  output logic [NUM_REQ-1:0]               gnt_o,
  output logic [NUM_REQ-1:0]               rvalid_o,
  output logic [WIDTH_DATA-1:0]            rdata_o,
  output logic                             busy_o,
  output logic                             ram_en_o,
  output logic                             ram_we_o,
  output logic [WIDTH_ADDR-1:0]            ram_addr_o,
  output logic [WIDTH_DATA-1:0]            ram_wdata_o,
  input  logic [WIDTH_DATA-1:0]            ram_rdata_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {ARB, OWN} state_t;

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                owner_q, owner_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic [NUM_REQ-1:0]              gnt_q, gnt_d;
  logic [RD_LAT-1:0]               tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0][IDX_W-1:0]    tag_idx_q, tag_idx_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  int               cand;
  int               nxt;
  logic             do_arb;
  logic             own_act;
  logic             rd_issue;

  // Round-robin search starting at the pointer, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
    nxt = (int'(win_idx) + 1) % NUM_REQ;
  end

  // Arbitrate when idle, or in the very cycle the owner lets go, so the
  // handover has no bubble. The releasing owner has req low and cannot win.
  assign do_arb = (state_q == ARB) || (!req_i[owner_q] && !lock_i[owner_q]);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    if (do_arb) begin
      if (win_found) begin
        state_d          = OWN;
        owner_d          = win_idx;
        ptr_d            = IDX_W'(nxt);
        gnt_d            = '0;
        gnt_d[win_idx]   = 1'b1;
      end else begin
        state_d = ARB;
        gnt_d   = '0;
      end
    end
  end

  // RAM port follows the owner combinationally; forced idle during reset.
  assign own_act  = rst && (state_q == OWN) && req_i[owner_q];
  assign rd_issue = own_act && !we_i[owner_q];

  always_comb begin
    ram_en_o    = own_act;
    ram_we_o    = own_act && we_i[owner_q];
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (own_act) begin
      ram_addr_o  = addr_i[int'(owner_q)*WIDTH_ADDR +: WIDTH_ADDR];
      ram_wdata_o = wdata_i[int'(owner_q)*WIDTH_DATA +: WIDTH_DATA];
    end
  end

  // Read tag shift pipeline: stage RD_LAT-1 lines up with ram_rdata_i.
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = rd_issue;
    tag_idx_d[0] = owner_q;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ARB;
      owner_q   <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (tag_vld_q[RD_LAT-1]) rvalid_o[tag_idx_q[RD_LAT-1]] = 1'b1;
  end

  assign gnt_o   = gnt_q;
  assign rdata_o = ram_rdata_i;
  assign busy_o  = (state_q == OWN) || (|tag_vld_q);

endmodule

// File: tb/tb_arb_bin_ram.sv
// Bench for arb_bin_ram: one instance with RD_LAT=1 and one with RD_LAT=3,
// both driven by the same stimulus, each with its own behavioural RAM.
module tb_arb_bin_ram;

  logic         clk;
  logic         rst;
  logic [3:0]   req, lock, we;
  logic [63:0]  addr;
  logic [127:0] wdata;

  logic [3:0]  gnt1, rv1, gnt3, rv3;
  logic [31:0] rdata1, rdata3, ramrd1, ramrd3;
  logic        busy1, busy3, en1, en3, wen1, wen3;
  logic [15:0] raddr1, raddr3;
  logic [31:0] rwd1, rwd3;

  arb_bin_ram #(.NUM_REQ(4), .WIDTH_ADDR(16), .WIDTH_DATA(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1),
    .rdata_o(rdata1), .busy_o(busy1), .ram_en_o(en1), .ram_we_o(wen1),
    .ram_addr_o(raddr1), .ram_wdata_o(rwd1), .ram_rdata_i(ramrd1));

  arb_bin_ram #(.NUM_REQ(4), .WIDTH_ADDR(16), .WIDTH_DATA(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_i(req), .lock_i(lock), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rv3),
    .rdata_o(rdata3), .busy_o(busy3), .ram_en_o(en3), .ram_we_o(wen3),
    .ram_addr_o(raddr3), .ram_wdata_o(rwd3), .ram_rdata_i(ramrd3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs; unwritten words read as 0xC0DE0000 | address.
  bit [31:0] mem1 [0:65535];
  bit        wr1  [0:65535];
  bit [31:0] mem3 [0:65535];
  bit        wr3  [0:65535];
  logic [31:0] p0, p1, p2;

  always @(posedge clk) begin
    if (en1 && wen1) begin
      mem1[raddr1] <= rwd1;
      wr1[raddr1]  <= 1'b1;
    end
    ramrd1 <= wr1[raddr1] ? mem1[raddr1] : (32'hC0DE0000 | {16'h0, raddr1});
  end

  always @(posedge clk) begin
    if (en3 && wen3) begin
      mem3[raddr3] <= rwd3;
      wr3[raddr3]  <= 1'b1;
    end
    p0 <= wr3[raddr3] ? mem3[raddr3] : (32'hC0DE0000 | {16'h0, raddr3});
    p1 <= p0;
    p2 <= p1;
  end
  assign ramrd3 = p2;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  req, lock, we;
    logic [3:0]  gnt;
    logic        en, wen;
    logic [15:0] addr;
    logic [3:0]  rv;
    logic [31:0] rdata;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [3:0] w,
                     input logic [3:0] g, input logic e, input logic ew,
                     input logic [15:0] a, input logic [3:0] v,
                     input logic [31:0] d, input logic b);
    vec_t x;
    x.req = r; x.lock = l; x.we = w; x.gnt = g; x.en = e; x.wen = ew;
    x.addr = a; x.rv = v; x.rdata = d; x.busy = b;
    tbl.push_back(x);
  endtask

  localparam logic [63:0]  ADDRS = {16'h3300, 16'h2200, 16'h0040, 16'h0010};
  localparam logic [127:0] WDATS = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};

  initial begin
    rst = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

    //   req      lock     we       gnt      en wen addr      rv       rdata          busy
    // two requesters, pointer 0: owner 0 writes twice, then 3 reads twice
    add(4'b1001, 4'b0000, 4'b0001, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);
    add(4'b1001, 4'b0000, 4'b0001, 4'b0001, 1, 1, 16'h0010, 4'b0000, 32'h0,         1);
    add(4'b1001, 4'b0000, 4'b0001, 4'b0001, 1, 1, 16'h0010, 4'b0000, 32'h0,         1);
    add(4'b1000, 4'b0000, 4'b0001, 4'b0001, 0, 0, 16'h0000, 4'b0000, 32'h0,         1);
    add(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 0, 16'h3300, 4'b0000, 32'h0,         1);
    add(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 0, 16'h3300, 4'b1000, 32'hC0DE3300, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 16'h0000, 4'b1000, 32'hC0DE3300, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);
    // pointer wrapped to 0: requester 0 beats 1, reads back its write
    add(4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);
    add(4'b0011, 4'b0000, 4'b0000, 4'b0001, 1, 0, 16'h0010, 4'b0000, 32'h0,         1);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0001, 0, 0, 16'h0000, 4'b0001, 32'hD0000000, 1);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 0, 16'h0040, 4'b0000, 32'h0,         1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 0, 16'h0000, 4'b0010, 32'hC0DE0040, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);
    // single read by requester 1
    add(4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);
    add(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 0, 16'h0040, 4'b0000, 32'h0,         1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 0, 16'h0000, 4'b0010, 32'hC0DE0040, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);
    // lock hold by requester 2 while requester 0 waits
    add(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);
    add(4'b0101, 4'b0100, 4'b0100, 4'b0100, 1, 1, 16'h2200, 4'b0000, 32'h0,         1);
    add(4'b0001, 4'b0100, 4'b0000, 4'b0100, 0, 0, 16'h0000, 4'b0000, 32'h0,         1);
    add(4'b0001, 4'b0100, 4'b0000, 4'b0100, 0, 0, 16'h0000, 4'b0000, 32'h0,         1);
    add(4'b0001, 4'b0100, 4'b0000, 4'b0100, 0, 0, 16'h0000, 4'b0000, 32'h0,         1);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0100, 0, 0, 16'h0000, 4'b0000, 32'h0,         1);
    add(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 16'h0010, 4'b0000, 32'h0,         1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 16'h0000, 4'b0001, 32'hD0000000, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);
    // lock without req never wins
    add(4'b0000, 4'b1000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);
    add(4'b0000, 4'b1000, 4'b0000, 4'b0000, 0, 0, 16'h0000, 4'b0000, 32'h0,         0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset gnt",    32'(gnt1),  32'h0);
    chk("reset rvalid", 32'(rv1),   32'h0);
    chk("reset busy",   32'(busy1), 32'h0);
    chk("reset ram_en", 32'(en1),   32'h0);
    chk("reset busy3",  32'(busy3), 32'h0);
    tick();
    rst = 1'b1;

    addr  = ADDRS;
    wdata = WDATS;
    foreach (tbl[i]) begin
      req = tbl[i].req; lock = tbl[i].lock; we = tbl[i].we;
      @(negedge clk);
      chk($sformatf("row%0d gnt", i),    32'(gnt1),   32'(tbl[i].gnt));
      chk($sformatf("row%0d en", i),     32'(en1),    32'(tbl[i].en));
      chk($sformatf("row%0d we", i),     32'(wen1),   32'(tbl[i].wen));
      chk($sformatf("row%0d addr", i),   32'(raddr1), 32'(tbl[i].addr));
      chk($sformatf("row%0d rvalid", i), 32'(rv1),    32'(tbl[i].rv));
      chk($sformatf("row%0d busy", i),   32'(busy1),  32'(tbl[i].busy));
      if (tbl[i].rv != 4'b0000) chk($sformatf("row%0d rdata", i), rdata1, tbl[i].rdata);
      tick();
    end

    // in-flight read across handover (RD_LAT=3 instance)
    req = '0; lock = '0; we = '0; rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1010;
    @(negedge clk); chk("inflt s0 gnt", 32'(gnt3), 32'h0); tick();
    @(negedge clk);
    chk("inflt s1 gnt",  32'(gnt3),   32'h2);
    chk("inflt s1 addr", 32'(raddr3), 32'h0040);
    tick();
    req = 4'b1000;
    @(negedge clk); chk("inflt s2 gnt", 32'(gnt3), 32'h2); tick();
    @(negedge clk);
    chk("inflt s3 gnt",    32'(gnt3), 32'h8);
    chk("inflt s3 en",     32'(en3),  32'h1);
    chk("inflt s3 rvalid", 32'(rv3),  32'h0);
    tick();
    req = 4'b0000; lock = 4'b1000;
    @(negedge clk);
    chk("inflt s4 gnt",    32'(gnt3), 32'h8);
    chk("inflt s4 rvalid", 32'(rv3),  32'h2);
    chk("inflt s4 rdata",  rdata3,    32'hC0DE0040);
    tick();
    @(negedge clk); chk("inflt s5 rvalid", 32'(rv3), 32'h0); tick();
    lock = 4'b0000;
    @(negedge clk);
    chk("inflt s6 rvalid", 32'(rv3), 32'h8);
    chk("inflt s6 rdata",  rdata3,   32'hC0DE3300);
    tick();
    @(negedge clk);
    chk("inflt s7 gnt",  32'(gnt3),  32'h0);
    chk("inflt s7 busy", 32'(busy3), 32'h0);
    tick();

    // reset with two reads in flight for owner 2
    req = 4'b0100;
    tick();
    @(negedge clk); chk("rstmid own gnt", 32'(gnt3), 32'h4); tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid en3 forced", 32'(en3), 32'h0);
    chk("rstmid en1 forced", 32'(en1), 32'h0);
    tick();
    rst = 1'b1; req = 4'b0000;
    @(negedge clk);
    chk("rstmid gnt",  32'(gnt3),  32'h0);
    chk("rstmid busy", 32'(busy3), 32'h0);
    chk("rstmid gnt1", 32'(gnt1),  32'h0);
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid rvalid c%0d", c), 32'({rv3, rv1}), 32'h0);
      tick();
    end
    req = 4'b0001;
    tick();
    @(negedge clk);
    chk("rstmid regrant", 32'(gnt3), 32'h1);
    tick();
    req = 4'b0000;
    tick();
    tick();

    // fairness: all requesters high, one write per ownership
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1111; we = 4'b1111;
    tick();
    for (int n = 0; n < 12; n++) begin
      int k;
      k = n % 4;
      for (int j = 0; j < 4; j++) begin
        addr[j*16 +: 16]  = 16'(j*16'h1000 + 16'h0100 + n);
        wdata[j*32 +: 32] = 32'(32'hF0000000 + j*256 + n);
      end
      req = 4'b1111;
      @(negedge clk);
      chk($sformatf("fair n%0d gnt", n),   32'(gnt1),   32'(1 << k));
      chk($sformatf("fair n%0d we", n),    32'(wen1),   32'h1);
      chk($sformatf("fair n%0d addr", n),  32'(raddr1), 32'(k*16'h1000 + 16'h0100 + n));
      chk($sformatf("fair n%0d wdata", n), rwd1,        32'(32'hF0000000 + k*256 + n));
      tick();
      req = 4'b1111 & ~4'(1 << k);
      @(negedge clk);
      chk($sformatf("fair n%0d idle en", n), 32'(en1), 32'h0);
      tick();
    end
    req = 4'b0000; we = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    for (int n = 0; n <= 12; n++) begin
      req = (n < 12) ? 4'b0001 : 4'b0000;
      addr = {48'h0, 16'((n % 4)*16'h1000 + 16'h0100 + n)};
      @(negedge clk);
      if (n < 12) chk($sformatf("rdbk n%0d en", n), 32'(en1), 32'h1);
      if (n > 0) begin
        chk($sformatf("rdbk n%0d rvalid", n - 1), 32'(rv1), 32'h1);
        chk($sformatf("rdbk n%0d rdata", n - 1), rdata1,
            32'(32'hF0000000 + ((n - 1) % 4)*256 + (n - 1)));
      end
      tick();
    end
    @(negedge clk);
    chk("final gnt", 32'(gnt1), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
